// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall merge, exception flush sequencing, stall watchdog.
// Optional performance counters are enabled with PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        except_req_i,
  input  logic [31:0] except_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        watchdog_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
);

  localparam int unsigned FW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_INIT =
    FW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_MAX =
    CNT_W'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              wd_q, wd_d;
  logic              req;
  logic              stalled;

  assign req = stallreq_id_i | stallreq_ex_i;

  // Gated by reset so the stall vector clears while reset is held.
  always_comb begin
    stall_o = 6'b000000;
    if (rst && state_q != FLUSH) begin
      priority case (1'b1)
        stallreq_ex_i: stall_o = 6'b001111;
        stallreq_id_i: stall_o = 6'b000111;
        default:       stall_o = 6'b000000;
      endcase
    end
  end

  assign stalled = (stall_o != 6'b000000);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    if (except_req_i) begin
      state_d = FLUSH;
      fcnt_d  = FLUSH_INIT;
      pc_d    = except_pc_i;
    end else begin
      unique case (state_q)
        RUN:   if (req) state_d = STALL;
        STALL: if (!req) state_d = RUN;
        FLUSH: begin
          if (fcnt_q == '0) begin
            state_d = req ? STALL : RUN;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    run_d = '0;
    if (state_q != FLUSH && stalled) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
    wd_d = wd_q | (run_d == RUN_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pc_q    <= '0;
      run_q   <= '0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      run_q   <= run_d;
      wd_q    <= wd_d;
    end
  end

  assign flush_o    = (state_q == FLUSH);
  assign new_pc_o   = pc_q;
  assign watchdog_o = wd_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pst_q, pst_d;
  logic [31:0] pfl_q, pfl_d;

  always_comb begin
    pst_d = pst_q;
    pfl_d = pfl_q;
    if (stalled && pst_q != 32'hFFFFFFFF) pst_d = pst_q + 32'd1;
    if (except_req_i && pfl_q != 32'hFFFFFFFF) pfl_d = pfl_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pst_q <= '0;
      pfl_q <= '0;
    end else begin
      pst_q <= pst_d;
      pfl_q <= pfl_d;
    end
  end

  assign perf_stall_o = pst_q;
  assign perf_flush_o = pfl_q;
`else
  assign perf_stall_o = 32'h0;
  assign perf_flush_o = 32'h0;
`endif

endmodule
